// File: rtl/tdp_ram_pkg.sv
// Shared types and constants for the clearable true dual-port RAM.
// Clear-sequencer state encodings and read-during-write mode selectors.
package tdp_ram_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/tdp_ram_clr_if.sv
// Bus bundle for tdp_ram_clr: both access ports plus the clear/collision sideband.
// The master drives requests and the slave (the RAM) returns data and status.
interface tdp_ram_clr_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);

  logic                  en_a;
  logic                  we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] din_a;
  logic [DATA_WIDTH-1:0] dout_a;
  logic                  valid_a;

  logic                  en_b;
  logic                  we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] din_b;
  logic [DATA_WIDTH-1:0] dout_b;
  logic                  valid_b;

  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;
  logic                  collision;

  modport master (
    output en_a, we_a, addr_a, din_a,
    output en_b, we_b, addr_b, din_b,
    output clr_start,
    input  dout_a, valid_a, dout_b, valid_b,
    input  clr_busy, clr_done, collision
  );

  modport slave (
    input  en_a, we_a, addr_a, din_a,
    input  en_b, we_b, addr_b, din_b,
    input  clr_start,
    output dout_a, valid_a, dout_b, valid_b,
    output clr_busy, clr_done, collision
  );

endinterface

// File: rtl/tdp_ram_clr_seq.sv
// Clear sequencer: walks the array once, one zero-write per cycle, then pulses done.
// The write address/enable it produces is muxed onto port A by the RAM top.
module tdp_ram_clr_seq
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr_start,
  output logic                  clr_busy,
  output logic                  clr_done,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  clr_state_e            state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The counter stops on the last word instead of wrapping, so the final write and
  // the move to DONE happen on the same edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_busy  = 1'b0;
    clr_done  = 1'b0;
    clr_we    = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        clr_busy = 1'b1;
        clr_we   = 1'b1;
        if (cnt == LAST_ADDR) state_nxt = DONE;
        else                  cnt_nxt   = cnt + ADDR_WIDTH'(1);
      end
      DONE: begin
        clr_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign clr_addr = cnt;

endmodule

// File: rtl/tdp_ram_clr.sv
// True dual-port RAM with selectable read-during-write, optional output register,
// same-address collision flag and a hardware clear that zeroes every word.
module tdp_ram_clr
  import tdp_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int RD_MODE    = RD_FIRST,
  parameter int OUT_REG    = 0
) (
  input  logic          clk,
  input  logic          rst,
  tdp_ram_clr_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  clr_busy, clr_done, clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  tdp_ram_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_seq (
    .clk       (clk),
    .rst       (rst),
    .clr_start (bus.clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

  logic acc_a, acc_b, in_a, in_b, same_addr, collision_c;
  logic wr_a, wr_b;

  assign acc_a       = bus.en_a & ~clr_busy;
  assign acc_b       = bus.en_b & ~clr_busy;
  assign in_a        = {1'b0, bus.addr_a} < DEPTH_L;
  assign in_b        = {1'b0, bus.addr_b} < DEPTH_L;
  assign same_addr   = bus.addr_a == bus.addr_b;
  assign collision_c = acc_a & acc_b & same_addr & (bus.we_a | bus.we_b);
  assign wr_a        = acc_a & bus.we_a & in_a;
  // Port A wins a write/write collision, so B's write is dropped there.
  assign wr_b        = acc_b & bus.we_b & in_b & ~(wr_a & same_addr);

  logic                  wa_en;
  logic [ADDR_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0] wa_data;

  assign wa_en   = clr_we | wr_a;
  assign wa_addr = clr_we ? clr_addr : bus.addr_a;
  assign wa_data = clr_we ? '0 : bus.din_a;

  always_ff @(posedge clk) begin
    if (wa_en) mem[wa_addr] <= wa_data;
    if (wr_b)  mem[bus.addr_b] <= bus.din_b;
  end

  // Array reads are taken before the edge, which gives read-first naturally;
  // write-first forwards whichever write data lands on the addressed word.
  logic [DATA_WIDTH-1:0] rd_a, rd_b;

  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_a) begin
      rd_a = mem[bus.addr_a];
      if (RD_MODE == WR_FIRST) begin
        if (bus.we_a)         rd_a = bus.din_a;
        else if (collision_c) rd_a = bus.din_b;
      end
    end
    if (in_b) begin
      rd_b = mem[bus.addr_b];
      if (RD_MODE == WR_FIRST) begin
        if (collision_c && bus.we_a) rd_b = bus.din_a;
        else if (bus.we_b)           rd_b = bus.din_b;
      end
    end
  end

  logic [DATA_WIDTH-1:0] dout1_a, dout1_b;
  logic                  valid1_a, valid1_b, collision_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout1_a     <= '0;
      dout1_b     <= '0;
      valid1_a    <= 1'b0;
      valid1_b    <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      valid1_a    <= acc_a;
      valid1_b    <= acc_b;
      collision_q <= collision_c;
      if (acc_a) dout1_a <= rd_a;
      if (acc_b) dout1_b <= rd_b;
    end
  end

  assign bus.collision = collision_q;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] dout2_a, dout2_b;
    logic                  valid2_a, valid2_b;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        dout2_a  <= '0;
        dout2_b  <= '0;
        valid2_a <= 1'b0;
        valid2_b <= 1'b0;
      end else begin
        valid2_a <= valid1_a;
        valid2_b <= valid1_b;
        if (valid1_a) dout2_a <= dout1_a;
        if (valid1_b) dout2_b <= dout1_b;
      end
    end

    assign bus.dout_a  = dout2_a;
    assign bus.dout_b  = dout2_b;
    assign bus.valid_a = valid2_a;
    assign bus.valid_b = valid2_b;
  end else begin : g_no_out_reg
    assign bus.dout_a  = dout1_a;
    assign bus.dout_b  = dout1_b;
    assign bus.valid_a = valid1_a;
    assign bus.valid_b = valid1_b;
  end

endmodule

// File: tb/tb_tdp_ram_clr.sv
// Scoreboard bench: one stimulus stream feeds three RAMs (read-first, write-first,
// read-first with output register) and a word-level model predicts each port's reads.
module tb_tdp_ram_clr;
  import tdp_ram_pkg::*;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int NDUT  = 3;

  typedef struct {
    int         ch;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       en_a = 1'b0, we_a = 1'b0, en_b = 1'b0, we_b = 1'b0, clr_start = 1'b0;
  logic [3:0] addr_a = '0, addr_b = '0;
  logic [7:0] din_a = '0, din_b = '0;

  logic       va_w [NDUT];
  logic       vb_w [NDUT];
  logic       coll_w [NDUT];
  logic       busy_w [NDUT];
  logic       done_w [NDUT];
  logic [7:0] da_w [NDUT];
  logic [7:0] db_w [NDUT];

  exp_t       sb [$];
  bit         coll_exp [int];
  logic [7:0] model [DEPTH];
  logic [7:0] last_d [2*NDUT];

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  tdp_ram_clr_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus [NDUT] ();

  // Instance 0: read-first, 1: write-first, 2: read-first with output register.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    assign bus[g].en_a      = en_a;
    assign bus[g].we_a      = we_a;
    assign bus[g].addr_a    = addr_a;
    assign bus[g].din_a     = din_a;
    assign bus[g].en_b      = en_b;
    assign bus[g].we_b      = we_b;
    assign bus[g].addr_b    = addr_b;
    assign bus[g].din_b     = din_b;
    assign bus[g].clr_start = clr_start;

    assign va_w[g]   = bus[g].valid_a;
    assign vb_w[g]   = bus[g].valid_b;
    assign da_w[g]   = bus[g].dout_a;
    assign db_w[g]   = bus[g].dout_b;
    assign coll_w[g] = bus[g].collision;
    assign busy_w[g] = bus[g].clr_busy;
    assign done_w[g] = bus[g].clr_done;

    tdp_ram_clr #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .RD_MODE    (g == 1 ? WR_FIRST : RD_FIRST),
      .OUT_REG    (g == 2 ? 1 : 0)
    ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    if (obs !== want) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, want);
    end
  endtask

  // Match a returned word against the oldest pending expectation for that port.
  task automatic checkPort(input int ch, input logic v, input logic [7:0] d);
    int    idx = -1;
    string tag;
    tag = $sformatf("dut%0d port%s", ch / 2, (ch % 2) != 0 ? "B" : "A");
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].ch == ch) begin
        idx = i;
        break;
      end
    end
    if (v) begin
      if (idx < 0) begin
        checkOutput({tag, " spurious valid"}, 32'(v), 32'(0));
      end else begin
        checkOutput({tag, " data"}, 32'(d), 32'(sb[idx].data));
        checkOutput({tag, " latency"}, cyc, sb[idx].cyc);
        last_d[ch] = sb[idx].data;
        sb.delete(idx);
      end
    end else begin
      checkOutput({tag, " hold"}, 32'(d), 32'(last_d[ch]));
      if (idx >= 0 && sb[idx].cyc <= cyc) begin
        checkOutput({tag, " valid"}, 32'(v), 32'(1));
        sb.delete(idx);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      for (int g = 0; g < NDUT; g++) begin
        checkPort(2 * g, va_w[g], da_w[g]);
        checkPort(2 * g + 1, vb_w[g], db_w[g]);
        checkOutput($sformatf("dut%0d collision", g), 32'(coll_w[g]), 32'(coll_exp.exists(cyc)));
      end
    end
  end

  // One cycle of port traffic; the model predicts every instance's result.
  task automatic applyStimulus(input logic ena, input logic wea, input logic [3:0] aa,
                               input logic [7:0] dina, input logic enb, input logic web,
                               input logic [3:0] ab, input logic [7:0] dinb);
    int         e;
    logic       ina, inb, coll;
    logic [7:0] old_a, old_b, wf_a, wf_b;
    @(negedge clk);
    en_a = ena; we_a = wea; addr_a = aa; din_a = dina;
    en_b = enb; we_b = web; addr_b = ab; din_b = dinb;
    e     = cyc + 1;
    ina   = 32'(aa) < DEPTH;
    inb   = 32'(ab) < DEPTH;
    coll  = ena && enb && (aa == ab) && (wea || web);
    old_a = ina ? model[aa] : 8'h00;
    old_b = inb ? model[ab] : 8'h00;
    wf_a  = !ina ? 8'h00 : (wea ? dina : (coll ? dinb : old_a));
    wf_b  = !inb ? 8'h00 : ((coll && wea) ? dina : (web ? dinb : old_b));
    if (coll) coll_exp[e] = 1'b1;
    if (ena) begin
      sb.push_back('{0, old_a, e});
      sb.push_back('{2, wf_a, e});
      sb.push_back('{4, old_a, e + 1});
    end
    if (enb) begin
      sb.push_back('{1, old_b, e});
      sb.push_back('{3, wf_b, e});
      sb.push_back('{5, old_b, e + 1});
    end
    if (ena && wea && ina) model[aa] = dina;
    if (enb && web && inb && !(ena && wea && aa == ab)) model[ab] = dinb;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  task automatic fillAll(input logic [7:0] v);
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, 1'b1, 4'(i), v, 1'b0, 1'b0, 4'h0, 8'h00);
    idle(3);
  endtask

  task automatic readAll();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'(i), 8'h00);
    idle(3);
  endtask

  task automatic checkResetState(input string pfx);
    for (int g = 0; g < NDUT; g++) begin
      checkOutput($sformatf("%s dut%0d valid_a", pfx, g), 32'(va_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d valid_b", pfx, g), 32'(vb_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d dout_a", pfx, g), 32'(da_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d dout_b", pfx, g), 32'(db_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d collision", pfx, g), 32'(coll_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d clr_busy", pfx, g), 32'(busy_w[g]), 32'(0));
      checkOutput($sformatf("%s dut%0d clr_done", pfx, g), 32'(done_w[g]), 32'(0));
    end
  endtask

  // Start a clear and hammer port A with writes it must ignore; either let it run
  // to completion or hit reset after the given number of cleared words.
  task automatic runClear(input int words);
    @(negedge clk);
    clr_start = 1'b1;
    en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; we_b = 1'b0;
    @(negedge clk);
    clr_start = 1'b0;
    for (int k = 0; k < words; k++) begin
      for (int g = 0; g < NDUT; g++) begin
        checkOutput($sformatf("dut%0d clr_busy cycle %0d", g, k), 32'(busy_w[g]), 32'(1));
        checkOutput($sformatf("dut%0d clr_done cycle %0d", g, k), 32'(done_w[g]), 32'(0));
      end
      en_a = 1'b1; we_a = 1'b1; addr_a = 4'(DEPTH - 1 - k); din_a = 8'h5A;
      @(negedge clk);
    end
    en_a = 1'b0; we_a = 1'b0;
    for (int i = 0; i < words; i++) model[i] = 8'h00;
    if (words == DEPTH) begin
      for (int g = 0; g < NDUT; g++) begin
        checkOutput($sformatf("dut%0d clr_busy after clear", g), 32'(busy_w[g]), 32'(0));
        checkOutput($sformatf("dut%0d clr_done pulse", g), 32'(done_w[g]), 32'(1));
      end
      @(negedge clk);
      for (int g = 0; g < NDUT; g++)
        checkOutput($sformatf("dut%0d clr_done single", g), 32'(done_w[g]), 32'(0));
    end else begin
      #2 rst = 1'b1;
      #1 checkResetState("abort");
      for (int i = 0; i < 2 * NDUT; i++) last_d[i] = 8'h00;
      @(negedge clk);
      #2 rst = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not reach the end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 2 * NDUT; i++) last_d[i] = 8'h00;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    #2 rst = 1'b0;

    $display("[TB] fill via A, read back via B");
    for (int i = 1; i <= DEPTH; i++)
      applyStimulus(1'b1, 1'b1, 4'(i - 1), 8'(i), 1'b0, 1'b0, 4'h0, 8'h00);
    readAll();

    $display("[TB] read-during-write collision on address 3");
    applyStimulus(1'b1, 1'b1, 4'h3, 8'hAA, 1'b1, 1'b0, 4'h3, 8'h00);
    applyStimulus(1'b0, 1'b0, 4'h0, 8'h00, 1'b1, 1'b0, 4'h3, 8'h00);

    $display("[TB] write/write collision on address 5");
    applyStimulus(1'b1, 1'b1, 4'h5, 8'h11, 1'b1, 1'b1, 4'h5, 8'h22);
    applyStimulus(1'b1, 1'b0, 4'h5, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    idle(3);

    $display("[TB] single read with idle cycles, read/read same address");
    applyStimulus(1'b1, 1'b0, 4'h2, 8'h00, 1'b0, 1'b0, 4'h0, 8'h00);
    idle(4);
    applyStimulus(1'b1, 1'b0, 4'h7, 8'h00, 1'b1, 1'b0, 4'h7, 8'h00);
    idle(2);

    $display("[TB] random traffic on a narrow address window");
    for (int k = 0; k < 60; k++)
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 8'($urandom));
    idle(3);

    $display("[TB] full clear");
    fillAll(8'hFF);
    runClear(DEPTH);
    idle(2);
    readAll();

    $display("[TB] clear aborted by reset");
    fillAll(8'hFF);
    runClear(8);
    idle(2);
    readAll();

    idle(4);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
